// File: rtl/dm_access_ctrl_if.sv
// Bus bundle between MEM stage, data memory and the access controller.
// slave = controller view, master = environment (MEM stage + memory) view.
interface dm_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_type, req_addr, req_wdata, mem_ready, mem_rdata,
        output req_ready, mem_en, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_type, req_addr, req_wdata, mem_ready, mem_rdata,
        input  req_ready, mem_en, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: packs stores into byte lanes, extracts/extends loads; one access in flight, rsp >=3 cycles after accept.
// req_ready is low while an access is outstanding; define DM_ALIGN_CHECK_EN to fault misaligned word/half accesses without touching memory.
module dm_access_ctrl #(
    parameter int unsigned WAIT_MAX = 15
) (
    input logic             clk,
    input logic             reset,
    dm_access_ctrl_if.slave bus
);
    localparam logic [2:0] T_LW  = 3'd0;
    localparam logic [2:0] T_LH  = 3'd1;
    localparam logic [2:0] T_LHU = 3'd2;
    localparam logic [2:0] T_LB  = 3'd3;
    localparam logic [2:0] T_LBU = 3'd4;
    localparam logic [2:0] T_SW  = 3'd5;
    localparam logic [2:0] T_SH  = 3'd6;
    localparam logic [2:0] T_SB  = 3'd7;

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t      state, state_nxt;
    req_t        req_q;
    logic        accept;
    logic [7:0]  cnt_q, cnt_nxt, cnt_inc;
    logic        rsp_valid_q, rsp_valid_nxt;
    logic        rsp_err_q, rsp_err_nxt;
    logic [31:0] rsp_data_q, rsp_data_nxt;
    logic        misaligned;
    logic [3:0]  lane_we;
    logic [31:0] lane_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_result;

`ifdef DM_ALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        case (bus.req_type)
            T_LW, T_SW:        misaligned = (bus.req_addr[1:0] != 2'b00);
            T_LH, T_LHU, T_SH: misaligned = bus.req_addr[0];
            default:           misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    // Store lanes come from the latched request so they stay stable through WAIT.
    always_comb begin
        lane_we    = 4'b0000;
        lane_wdata = 32'h0;
        case (req_q.typ)
            T_SW: begin
                lane_we    = 4'b1111;
                lane_wdata = req_q.wdata;
            end
            T_SH: begin
                lane_we    = req_q.addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{req_q.wdata[15:0]}};
            end
            T_SB: begin
                lane_we    = 4'b0001 << req_q.addr[1:0];
                lane_wdata = {4{req_q.wdata[7:0]}};
            end
            default: begin
                lane_we    = 4'b0000;
                lane_wdata = 32'h0;
            end
        endcase
    end

    always_comb begin
        ld_byte = 8'h0;
        case (req_q.addr[1:0])
            2'd0:    ld_byte = bus.mem_rdata[7:0];
            2'd1:    ld_byte = bus.mem_rdata[15:8];
            2'd2:    ld_byte = bus.mem_rdata[23:16];
            default: ld_byte = bus.mem_rdata[31:24];
        endcase
        ld_half = req_q.addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        ld_result = 32'h0;
        case (req_q.typ)
            T_LW:    ld_result = bus.mem_rdata;
            T_LH:    ld_result = {{16{ld_half[15]}}, ld_half};
            T_LHU:   ld_result = {16'h0, ld_half};
            T_LB:    ld_result = {{24{ld_byte[7]}}, ld_byte};
            T_LBU:   ld_result = {24'h0, ld_byte};
            default: ld_result = 32'h0;
        endcase
    end

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt_q;
        accept        = 1'b0;
        rsp_valid_nxt = 1'b0;
        rsp_err_nxt   = 1'b0;
        rsp_data_nxt  = 32'h0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (misaligned) begin
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
                cnt_nxt   = 8'd0;
            end
            WAIT: begin
                // A completion on the final wait cycle beats the timeout.
                if (bus.mem_ready) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_data_nxt  = ld_result;
                    state_nxt     = IDLE;
                end else if (cnt_inc == WAIT_LIM) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                    state_nxt     = IDLE;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt_q       <= 8'd0;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 32'h0;
        end else begin
            state       <= state_nxt;
            cnt_q       <= cnt_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            rsp_err_q   <= rsp_err_nxt;
            rsp_data_q  <= rsp_data_nxt;
            if (accept) begin
                req_q.typ   <= bus.req_type;
                req_q.addr  <= bus.req_addr;
                req_q.wdata <= bus.req_wdata;
            end
        end
    end

    logic busy;
    assign busy = (state == ISSUE) || (state == WAIT);

    assign bus.req_ready = (state == IDLE);
    assign bus.mem_en    = (state == ISSUE);
    assign bus.mem_we    = busy ? lane_we : 4'b0000;
    assign bus.mem_addr  = busy ? {req_q.addr[31:2], 2'b00} : 32'h0;
    assign bus.mem_wdata = busy ? lane_wdata : 32'h0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: per-cycle expected outputs from a transaction-level model, random plus directed traffic.
module tb_dm_access_ctrl;
    localparam int WM   = 15;
    localparam int MAXC = 16384;

    logic clk = 1'b0;
    logic reset;
    dm_access_ctrl_if bus ();

    dm_access_ctrl #(.WAIT_MAX(WM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    bit          exp_ready [MAXC];
    bit          exp_en    [MAXC];
    logic [3:0]  exp_we    [MAXC];
    logic [31:0] exp_addr  [MAXC];
    logic [31:0] exp_wdata [MAXC];
    bit          exp_rv    [MAXC];
    bit          exp_rerr  [MAXC];
    logic [31:0] exp_rdata [MAXC];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s at cycle %0d: got 0x%08h, want 0x%08h", nm, cyc, act, expv);
        end
    endtask

    function automatic bit misal(input logic [2:0] t, input logic [31:0] a);
`ifdef DM_ALIGN_CHECK_EN
        if (t == 3'd0 || t == 3'd5) return (a % 4) != 0;
        if (t == 3'd1 || t == 3'd2 || t == 3'd6) return (a % 2) != 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] t, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        v = 32'h0;
        case (t)
            3'd0: v = rd;
            3'd1, 3'd2: begin
                v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
                if (t == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
            end
            3'd3, 3'd4: begin
                v = (rd >> (8 * (a % 4))) & 32'hFF;
                if (t == 3'd3 && v[7]) v = v | 32'hFFFF_FF00;
            end
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] store_we(input logic [2:0] t, input logic [31:0] a);
        if (t == 3'd5) return 4'hF;
        if (t == 3'd6) return ((a / 2) % 2 == 1) ? 4'b1100 : 4'b0011;
        if (t == 3'd7) return 4'(1 << (a % 4));
        return 4'h0;
    endfunction

    function automatic logic [31:0] store_wd(input logic [2:0] t, input logic [31:0] wd);
        if (t == 3'd5) return wd;
        if (t == 3'd6) return {wd[15:0], wd[15:0]};
        if (t == 3'd7) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        return 32'h0;
    endfunction

    // Fill the expected timeline of one transaction accepted at cycle a0.
    task automatic plan(input int a0, input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd,
                        input int d, input logic [31:0] rd);
        int n;
        int r;
        bit err;
        if (a0 + WM + 4 >= MAXC) return;
        if (misal(t, a)) begin
            exp_rv[a0 + 1]    = 1'b1;
            exp_rerr[a0 + 1]  = 1'b1;
            exp_rdata[a0 + 1] = 32'h0;
            return;
        end
        err = (d > WM);
        n   = err ? WM : d;
        r   = a0 + 2 + n;
        exp_en[a0 + 1] = 1'b1;
        for (int c = a0 + 1; c < r; c++) begin
            exp_ready[c] = 1'b0;
            exp_we[c]    = store_we(t, a);
            exp_addr[c]  = a & 32'hFFFF_FFFC;
            exp_wdata[c] = store_wd(t, wd);
        end
        exp_rv[r]    = 1'b1;
        exp_rerr[r]  = err;
        exp_rdata[r] = (err || t >= 3'd5) ? 32'h0 : load_val(t, a, rd);
    endtask

    task automatic noise();
        bus.mem_ready = 1'($urandom % 2);
        bus.mem_rdata = $urandom;
    endtask

    // Drive one request; d = cycles from mem_en to mem_ready (d > WM means never).
    // Returns at the response cycle, 1 ns after its rising edge.
    task automatic run_txn(input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd,
                           input int d, input logic [31:0] rd, input int gap, output int a0);
        repeat (gap) begin
            bus.req_valid = 1'b0;
            noise();
            @(posedge clk); #1;
        end
        a0 = cyc;
        bus.req_valid = 1'b1;
        bus.req_type  = t;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        noise();
        plan(a0, t, a, wd, d, rd);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_type  = 3'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        noise();
        if (misal(t, a)) return;
        @(posedge clk); #1;
        for (int k = 1; k <= WM; k++) begin
            bus.mem_ready = (k == d);
            bus.mem_rdata = (k == d) ? rd : $urandom;
            @(posedge clk); #1;
            if (k == d) break;
        end
        bus.mem_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            cmp("req_ready", 32'(bus.req_ready), 32'(exp_ready[cyc]));
            cmp("mem_en",    32'(bus.mem_en),    32'(exp_en[cyc]));
            cmp("mem_we",    32'(bus.mem_we),    32'(exp_we[cyc]));
            cmp("mem_addr",  bus.mem_addr,       exp_addr[cyc]);
            cmp("mem_wdata", bus.mem_wdata,      exp_wdata[cyc]);
            cmp("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv[cyc]));
            cmp("rsp_err",   32'(bus.rsp_err),   32'(exp_rerr[cyc]));
            cmp("rsp_data",  bus.rsp_data,       exp_rdata[cyc]);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a0;
        int r;
        int d;
        logic [2:0] t;
        for (int i = 0; i < MAXC; i++) begin
            exp_ready[i] = 1'b1; exp_en[i] = 1'b0; exp_we[i] = 4'h0; exp_addr[i] = 32'h0;
            exp_wdata[i] = 32'h0; exp_rv[i] = 1'b0; exp_rerr[i] = 1'b0; exp_rdata[i] = 32'h0;
        end
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_type = 3'd0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("rst_req_ready", 32'(bus.req_ready), 32'd1);
        cmp("rst_mem_en",    32'(bus.mem_en),    32'd0);
        cmp("rst_mem_we",    32'(bus.mem_we),    32'd0);
        cmp("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        cmp("rst_rsp_data",  bus.rsp_data,       32'd0);
        @(posedge clk); #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Directed loads with hand-computed results
        run_txn(3'd3, 32'h1003, 32'h0, 1, 32'h80FF_1234, 0, a0);
        cmp("lb_data", bus.rsp_data, 32'hFFFF_FF80);
        cmp("lb_latency", 32'(cyc - a0), 32'd3);
        cmp("lb_model", exp_rdata[cyc], 32'hFFFF_FF80);
        run_txn(3'd4, 32'h1003, 32'h0, 1, 32'h80FF_1234, 1, a0);
        cmp("lbu_data", bus.rsp_data, 32'h0000_0080);
        cmp("lbu_model", exp_rdata[cyc], 32'h0000_0080);
        run_txn(3'd1, 32'h2002, 32'h0, 2, 32'h8001_7FFF, 0, a0);
        cmp("lh_data", bus.rsp_data, 32'hFFFF_8001);
        run_txn(3'd2, 32'h2002, 32'h0, 3, 32'h8001_7FFF, 0, a0);
        cmp("lhu_data", bus.rsp_data, 32'h0000_8001);
        cmp("lhu_model", exp_rdata[cyc], 32'h0000_8001);

        // Directed stores
        run_txn(3'd6, 32'h3002, 32'hDEAD_BEEF, 2, 32'h0, 0, a0);
        cmp("sh_model_we", 32'(exp_we[a0 + 1]), 32'hC);
        cmp("sh_model_wdata", exp_wdata[a0 + 1], 32'hBEEF_BEEF);
        cmp("sh_model_addr", exp_addr[a0 + 1], 32'h3000);
        cmp("sh_rsp_data", bus.rsp_data, 32'h0);
        run_txn(3'd7, 32'h3001, 32'h0000_00A5, 1, 32'h0, 0, a0);
        cmp("sb_model_we", 32'(exp_we[a0 + 1]), 32'h2);
        cmp("sb_model_wdata", exp_wdata[a0 + 1], 32'hA5A5_A5A5);

        // Timeout, then mem_ready on the last allowed wait cycle
        run_txn(3'd0, 32'h5000, 32'h0, 1000, 32'h0, 0, a0);
        cmp("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        cmp("to_rsp_err", 32'(bus.rsp_err), 32'd1);
        cmp("to_cycles_after_en", 32'(cyc - (a0 + 1)), 32'd16);
        cmp("to_req_ready", 32'(bus.req_ready), 32'd1);
        run_txn(3'd0, 32'h5004, 32'h0, WM, 32'h1234_5678, 0, a0);
        cmp("limit_err", 32'(bus.rsp_err), 32'd0);
        cmp("limit_data", bus.rsp_data, 32'h1234_5678);

        // Misaligned word load
        run_txn(3'd0, 32'h4002, 32'h0, 1, 32'h1234_5678, 0, a0);
`ifdef DM_ALIGN_CHECK_EN
        cmp("mis_err", 32'(bus.rsp_err), 32'd1);
        cmp("mis_latency", 32'(cyc - a0), 32'd1);
        cmp("mis_model_no_en", 32'(exp_en[a0 + 1]), 32'd0);
`else
        cmp("mis_model_addr", exp_addr[a0 + 1], 32'h4000);
        cmp("mis_data", bus.rsp_data, 32'h1234_5678);
        cmp("mis_latency", 32'(cyc - a0), 32'd3);
`endif

        // Random traffic
        repeat (300) begin
            t = 3'($urandom % 8);
            r = int'($urandom % 10);
            if (r < 7)      d = 1 + int'($urandom % 4);
            else if (r < 9) d = 1 + int'($urandom % WM);
            else            d = WM + 1 + int'($urandom % 3);
            run_txn(t, $urandom, $urandom, d, $urandom, int'($urandom % 3), a0);
        end

        // Reset in the middle of WAIT, then a stray mem_ready
        @(negedge clk); #1;
        chk_en = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_type = 3'd0; bus.req_addr = 32'h6000; bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        cmp("pre_rst_busy", 32'(bus.req_ready), 32'd0);
        #3 reset = 1'b1;
        #1;
        cmp("arst_req_ready", 32'(bus.req_ready), 32'd1);
        cmp("arst_mem_en",    32'(bus.mem_en),    32'd0);
        cmp("arst_mem_we",    32'(bus.mem_we),    32'd0);
        cmp("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        cmp("late_ready_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        cmp("late_ready_rsp_valid2", 32'(bus.rsp_valid), 32'd0);
        cmp("late_ready_req_ready", 32'(bus.req_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
